pci_target_mem: RTL
===================

# pci_target_mem

PCI bus target (responder) with a small internal word memory, the counterpart to the initiator side of `Device`. It watches FRAME/AD/C_BE for an address phase matching `DEVICE_ADDRESS`, claims the transaction with DEVSEL, and completes write or read bursts with TRDY. Read bursts include the bus turnaround cycle. It sits on the shared PCI bus alongside the existing devices and is the write/read sink used in system tests.

## Interface
- `DEPTH`, 4: number of 32-bit memory words; power of two; burst index wraps modulo DEPTH.
- `WAIT_STATES`, 0: TRDY-high cycles inserted before every data phase (0..3).
- `WRITE_CMD`, 4'b0100: C_BE command code for write.
- `READ_CMD`, 4'b0001: C_BE command code for read.
- `clk`  input  1  sole clock; every action happens on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `FRAME`  input  1  active-low; initiator transaction framing.
- `IRDY`  input  1  active-low initiator ready.
- `AD`  inout  32  address in the address phase, data in data phases; this block drives it only during read data phases.
- `C_BE`  input  4  command in the address phase; active-high byte enables in data phases (bit i = byte i).
- `TRDY`  inout  1  active-low target ready; z when not claimed.
- `DEVSEL`  inout  1  active-low device select; z when not claimed.
- `DEVICE_ADDRESS`  input  32  address this target answers to.
- `busy`  output  1  high from claim through release cycle.

## Operation
- States: IDLE, BUS_BUSY, CLAIM, DATA, RELEASE.
- IDLE: on a rising edge with FRAME=0 (previous sample FRAME=1):
  - AD==DEVICE_ADDRESS and C_BE is WRITE_CMD or READ_CMD -> latch the command, clear the index, load the wait counter -> CLAIM.
  - Otherwise -> BUS_BUSY, which returns to IDLE once FRAME=1 and IRDY=1 are sampled together.
- CLAIM: DEVSEL is driven 0 and TRDY is driven 1.
  - Write: stay for WAIT_STATES cycles.
  - Read: stay for max(1, WAIT_STATES) cycles; the first cycle is turnaround and AD stays z.
  - Then -> DATA.
- DATA: TRDY=0. For reads, AD is driven with mem[index].
  - A phase completes on an edge with IRDY=0 and TRDY=0.
  - Write completion: mem[index] byte i <= AD byte i for each C_BE[i]=1; other bytes are unchanged.
  - Any completion: index <= (index+1) mod DEPTH.
  - If FRAME=1 at completion (last phase) -> RELEASE.
  - Else if WAIT_STATES>0 -> CLAIM with TRDY=1 for WAIT_STATES cycles; no extra turnaround on reads.
  - Else stay in DATA; read AD shows the next word in the following cycle.
  - IRDY=1: hold TRDY=0 and keep AD stable; no state change.
- Initiator drops FRAME=1 and IRDY=1 without completing a phase (abort): -> RELEASE, memory unchanged.
- RELEASE: drive TRDY=1 and DEVSEL=1 for exactly one cycle, and release AD to z. Then release TRDY and DEVSEL to z and go to IDLE. A new address phase is not recognised until IDLE.
- `busy` = 1 in CLAIM, DATA and RELEASE.

## Timing
- Reset (sampled rst=1):
  - Next cycle: AD, TRDY and DEVSEL are z.
  - busy=0, state IDLE, index=0, all memory words 32'h0.
  - Reset overrides any in-flight transaction with no RELEASE cycle.
- Edge numbering: A = address-phase edge.
  - DEVSEL=0 from cycle A+1 (medium decode).
  - Write, WAIT_STATES=0: TRDY=0 from A+1; first completion possible at edge A+2.
  - Read, WAIT_STATES=0: AD z during A+1; AD valid and TRDY=0 from A+2; first completion possible at edge A+3.
- Zero-wait burst: one word per clock while IRDY=0.
- Memory write takes effect at the completion edge; a read of the same word one phase later sees the new value.
- Index wrap: a burst longer than DEPTH continues at word 0.
- Completion on the same edge as rst=1: reset wins and the write is discarded.

## Test plan
- Write of 3 words 32'hAA, 32'hBB, 32'hCC, BE=4'hF, DEVICE_ADDRESS=32'hBD, zero waits -> DEVSEL=0 at A+1, mem[0..2]=AA,BB,CC, one RELEASE cycle driving 1s, then z.
- Read of 2 words after that write -> AD z at A+1, 32'hAA at A+2, 32'hBB next cycle; TRDY=0 from A+2.
- Single write with C_BE=4'b0010 and AD=32'h1234_5678 over mem[0]=32'hAA -> mem[0]=32'h0000_56AA.
- Address 32'hAD -> DEVSEL/TRDY stay z and busy=0 for the whole transaction; a following 32'hBD transaction is claimed.
- WAIT_STATES=2, 2-word write with IRDY held high 1 cycle on phase 2 -> two TRDY-high cycles before each phase; TRDY held low with data unchanged during the IRDY stall.
- rst pulsed mid read burst -> all three buses z next cycle, busy=0, mem all zero, and the next valid transaction is claimed normally.

Source files
------------

// File: rtl/pci_target_mem_if.sv
// PCI target bus bundle: shared tri-state AD/TRDY/DEVSEL plus initiator-driven controls.
// Each side presents a value/enable pair; the shared wires resolve here.
interface pci_target_mem_if;
  logic        FRAME;
  logic        IRDY;
  logic [3:0]  C_BE;

  // Initiator-side AD driver
  logic [31:0] ad_m;
  logic        ad_m_oe;

  // Target-side drivers
  logic [31:0] ad_t;
  logic        ad_t_oe;
  logic        trdy_t;
  logic        trdy_oe;
  logic        devsel_t;
  logic        devsel_oe;

  wire  [31:0] AD;
  wire         TRDY;
  wire         DEVSEL;

  assign AD     = ad_t_oe   ? ad_t     : 'z;
  assign AD     = ad_m_oe   ? ad_m     : 'z;
  assign TRDY   = trdy_oe   ? trdy_t   : 1'bz;
  assign DEVSEL = devsel_oe ? devsel_t : 1'bz;

  modport master (
    output FRAME, IRDY, C_BE, ad_m, ad_m_oe,
    input  AD, TRDY, DEVSEL
  );

  modport slave (
    input  FRAME, IRDY, C_BE, AD,
    output ad_t, ad_t_oe, trdy_t, trdy_oe, devsel_t, devsel_oe
  );
endinterface

// File: rtl/pci_target_mem.sv
// PCI target with a small word memory: claims matching write/read transactions
// with DEVSEL (medium decode) and completes bursts with TRDY, optional wait states.
module pci_target_mem #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [3:0]  WRITE_CMD   = 4'b0100,
  parameter logic [3:0]  READ_CMD    = 4'b0001
) (
  input  logic                  clk,
  input  logic                  rst,
  pci_target_mem_if.slave       bus,
  input  logic [31:0]           DEVICE_ADDRESS,
  output logic                  busy
);

  localparam int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0]  WS    = 2'(WAIT_STATES);
  // Reads always spend at least one CLAIM cycle on the AD turnaround.
  localparam logic [1:0]  RD_WS = (WAIT_STATES == 0) ? 2'd1 : WS;

  typedef enum logic [2:0] {IDLE, BUS_BUSY, CLAIM, DATA, RELEASE} state_t;

  state_t          state, state_n;
  logic            frame_q;
  logic            is_read, is_read_n;
  logic [IW-1:0]   index, index_n;
  logic [1:0]      wait_cnt, wait_n;
  logic [31:0]     mem [DEPTH];

  logic            addr_phase;
  logic            hit;
  logic            complete;

  always_comb begin
    addr_phase = frame_q && !bus.FRAME;
    hit        = (bus.AD == DEVICE_ADDRESS) &&
                 ((bus.C_BE == WRITE_CMD) || (bus.C_BE == READ_CMD));
    complete   = (state == DATA) && !bus.IRDY;

    state_n   = state;
    is_read_n = is_read;
    index_n   = index;
    wait_n    = wait_cnt;

    case (state)
      IDLE: begin
        if (addr_phase) begin
          if (hit) begin
            is_read_n = (bus.C_BE == READ_CMD);
            index_n   = '0;
            wait_n    = (bus.C_BE == READ_CMD) ? RD_WS : WS;
            state_n   = (wait_n == 2'd0) ? DATA : CLAIM;
          end else begin
            state_n = BUS_BUSY;
          end
        end
      end
      BUS_BUSY: begin
        if (bus.FRAME && bus.IRDY) state_n = IDLE;
      end
      CLAIM: begin
        if (bus.FRAME && bus.IRDY) begin
          state_n = RELEASE;
        end else if (wait_cnt <= 2'd1) begin
          state_n = DATA;
        end else begin
          wait_n = wait_cnt - 2'd1;
        end
      end
      DATA: begin
        if (complete) begin
          index_n = index + 1'b1;
          if (bus.FRAME) begin
            state_n = RELEASE;
          end else if (WS != 2'd0) begin
            wait_n  = WS;
            state_n = CLAIM;
          end
        end else if (bus.FRAME && bus.IRDY) begin
          state_n = RELEASE;
        end
      end
      RELEASE: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    bus.devsel_oe = (state == CLAIM) || (state == DATA) || (state == RELEASE);
    bus.trdy_oe   = bus.devsel_oe;
    bus.devsel_t  = (state == RELEASE);
    bus.trdy_t    = (state != DATA);
    bus.ad_t_oe   = is_read && (state == DATA);
    bus.ad_t      = mem[index];
    busy          = bus.devsel_oe;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      frame_q  <= 1'b1;
      is_read  <= 1'b0;
      index    <= '0;
      wait_cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state    <= state_n;
      frame_q  <= bus.FRAME;
      is_read  <= is_read_n;
      index    <= index_n;
      wait_cnt <= wait_n;
      if (complete && !is_read) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (bus.C_BE[b]) mem[index][8*b +: 8] <= bus.AD[8*b +: 8];
        end
      end
    end
  end

endmodule
